// File: rtl/ftf_rx_dec_28_pkg.sv
// ftf_pkg: shared widths, Fibonacci weights, FSM states and FTF pair rule for the 28-wire bus
package ftf_pkg;
    localparam int FBLEN28 = 20;
    localparam int FTF_WIRES = 28;
    localparam int BITS_PER_CYC = 7;
    localparam logic [FBLEN28-1:0] FTF_W [0:FTF_WIRES-1] = '{
        20'd1, 20'd1, 20'd2, 20'd3, 20'd5, 20'd8, 20'd13,
        20'd21, 20'd34, 20'd55, 20'd89, 20'd144, 20'd233, 20'd377,
        20'd610, 20'd987, 20'd1597, 20'd2584, 20'd4181, 20'd6765, 20'd10946,
        20'd17711, 20'd28657, 20'd46368, 20'd75025, 20'd121393, 20'd196418, 20'd317811
    };
    typedef enum logic [1:0] {IDLE, ACC, DONE} ftf_state_e;
    function automatic logic ftf_legal28(input logic [FTF_WIRES-1:0] t);
        logic bad;
        bad = 1'b0;
        for (int j = 0; j < FTF_WIRES - 1; j++)
            bad |= j[0] ? (t[j] & ~t[j+1]) : (~t[j] & t[j+1]);
        return ~bad;
    endfunction
endpackage

// File: rtl/ftf_rx_dec_28_if.sv
// ftf_rx_dec_28_if: codeword-in / payload-out valid-ready bundle
interface ftf_rx_dec_28_if;
    import ftf_pkg::*;
    logic in_valid;
    logic in_ready;
    logic [FTF_WIRES-1:0] tsv;
    logic out_valid;
    logic out_ready;
    logic [FBLEN28-1:0] dataout;
    logic out_err;
    modport master (output in_valid, tsv, out_ready, input in_ready, out_valid, dataout, out_err);
    modport slave (input in_valid, tsv, out_ready, output in_ready, out_valid, dataout, out_err);
endinterface

// File: rtl/ftf_legal_chk_28.sv
// ftf_legal_chk_28: combinational FTF legality check of one 28-bit codeword
module ftf_legal_chk_28 import ftf_pkg::*; (
    input  logic [FTF_WIRES-1:0] tsv,
    output logic                 legal
);
    assign legal = ftf_legal28(tsv);
endmodule

// File: rtl/ftf_rx_dec_28.sv
// ftf_rx_dec_28: iterative FTF decoder, 7 weighted bits per cycle, with error flag and counter
module ftf_rx_dec_28 import ftf_pkg::*; (
    input  logic            clock,
    input  logic            reset_n,
    ftf_rx_dec_28_if.slave  bus,
    input  logic            clr_err,
    output logic [15:0]     err_count
);
    logic [1:0] state;
    logic [1:0] cnt;
    logic [FTF_WIRES-1:0] sr;
    logic [FBLEN28-1:0] acc;
    logic [FBLEN28-1:0] part;
    logic err;
    logic legal;
    logic accept;
    logic retire;
    ftf_legal_chk_28 u_chk (.tsv(bus.tsv), .legal(legal));
    assign accept = state == IDLE && bus.in_valid;
    assign retire = state == DONE && bus.out_ready;
    assign bus.in_ready = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.dataout = acc;
    assign bus.out_err = err;
    // sr shifts down each cycle, so the current slice always sits in the low bits
    always_comb begin
        part = '0;
        for (int i = 0; i < BITS_PER_CYC; i++)
            part += sr[i] ? FTF_W[5'(BITS_PER_CYC * int'(cnt) + i)] : '0;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt <= '0;
            sr <= '0;
            acc <= '0;
            err <= 1'b0;
            err_count <= '0;
        end else begin
            if (accept) begin
                state <= ACC;
                cnt <= '0;
                sr <= bus.tsv;
                acc <= '0;
                err <= ~legal;
            end else if (state == ACC) begin
                acc <= acc + part;
                sr <= sr >> BITS_PER_CYC;
                cnt <= cnt + 2'd1;
                state <= cnt == 2'd3 ? DONE : ACC;
            end else if (retire)
                state <= IDLE;
            if (clr_err)
                err_count <= {15'b0, retire & err};
            else if (retire & err & ~&err_count)
                err_count <= err_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_ftf_rx_dec_28.sv
// tb_ftf_rx_dec_28: scoreboard bench for the FTF receive decoder
module tb_ftf_rx_dec_28;
    typedef struct {
        logic [19:0] d;
        logic        e;
    } exp_t;
    logic clock = 0;
    logic reset_n = 0;
    logic clr_err = 0;
    logic [15:0] err_count;
    logic rnd_mode = 0;
    logic rnd_rdy = 0;
    logic rdy_hold = 1;
    int n_tests = 0;
    int n_fail = 0;
    exp_t q[$];
    ftf_rx_dec_28_if bus();
    ftf_rx_dec_28 dut (.clock(clock), .reset_n(reset_n), .bus(bus.slave), .clr_err(clr_err), .err_count(err_count));
    assign bus.out_ready = rnd_mode ? rnd_rdy : rdy_hold;
    always #5 clock = ~clock;
    always @(posedge clock) begin
        #1;
        rnd_rdy = ($urandom_range(0, 3) != 0);
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    function automatic int fib(int k);
        int a = 1;
        int b = 1;
        int t;
        for (int i = 1; i < k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction
    // MSB-first encoder: odd wires need both even neighbours set, so a bit is
    // either forced by the wire above it or set only when the lower wires cannot cover the rest
    function automatic logic [27:0] enc(int v);
        logic [27:0] t = '0;
        int r = v;
        logic b;
        for (int k = 27; k >= 0; k--) begin
            if (k < 27 && k % 2 == 1 && !t[k+1]) b = 1'b0;
            else if (k < 27 && k % 2 == 0 && t[k+1]) b = 1'b1;
            else b = r > (k % 2 == 0 ? fib(k) - 1 : fib(k + 1) - 1);
            if (b) begin
                t[k] = 1'b1;
                r -= fib(k);
            end
        end
        return t;
    endfunction
    task automatic send(input logic [27:0] w, input bit push, input logic [19:0] d, input logic e);
        int n = 0;
        exp_t x;
        while (!bus.in_ready && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
        if (push) begin
            x.d = d;
            x.e = e;
            q.push_back(x);
        end
        bus.tsv = w;
        bus.in_valid = 1;
        @(posedge clock);
        #1;
        bus.in_valid = 0;
        bus.tsv = 28'($urandom);
    endtask
    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 500) begin
            @(posedge clock);
            n++;
        end
        #1;
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    endtask
    task automatic wait_valid();
        int n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!bus.out_valid) chk("valid_timeout", 0, 1);
    endtask
    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_dataout"}, bus.dataout, 0);
        chk({tag, "_out_err"}, bus.out_err, 0);
        chk({tag, "_err_count"}, err_count, 0);
    endtask
    always @(negedge clock) begin
        exp_t x;
        if (reset_n && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) chk("unexpected_out", 1, 0);
            else begin
                x = q.pop_front();
                chk("dataout", bus.dataout, x.d);
                chk("out_err", bus.out_err, x.e);
            end
        end
    end
    initial begin
        time t0;
        int v;
        bus.in_valid = 0;
        bus.tsv = '0;
        #2;
        chk_reset("rst");
        @(posedge clock);
        #1;
        reset_n = 1;
        send(28'h0000001, 1, 20'd1, 1'b0);
        repeat (3) begin
            @(posedge clock);
            #1;
            chk("lat_valid_lo", bus.out_valid, 0);
        end
        @(posedge clock);
        #1;
        chk("lat_valid_hi", bus.out_valid, 1);
        drain();
        chk("err_count_first", err_count, 0);
        send(28'hFFFFFFF, 1, 20'd832039, 1'b0);
        t0 = $time;
        send(28'h0000004, 1, 20'd2, 1'b0);
        chk("throughput", 32'(($time - t0) / 10), 6);
        send(28'h0000002, 1, 20'd1, 1'b1);
        send(28'h0000003, 1, 20'd2, 1'b1);
        send(28'h0000004, 1, 20'd2, 1'b0);
        drain();
        chk("err_count_two", err_count, 2);
        rdy_hold = 0;
        send(28'h0000005, 1, 20'd3, 1'b0);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            bus.in_valid = (i == 4);
            bus.tsv = 28'hFFFFFFF;
            chk("stall_dataout", bus.dataout, 3);
            chk("stall_out_err", bus.out_err, 0);
            chk("stall_in_ready", bus.in_ready, 0);
            chk("stall_out_valid", bus.out_valid, 1);
        end
        bus.in_valid = 0;
        rdy_hold = 1;
        drain();
        repeat (10) @(posedge clock);
        #1;
        chk("idle_after_stall", bus.in_ready, 1);
        chk("err_count_stall", err_count, 2);
        send(28'h0000004, 0, 20'd0, 1'b0);
        @(posedge clock);
        #1;
        reset_n = 0;
        #1;
        chk_reset("midacc");
        @(posedge clock);
        #1;
        reset_n = 1;
        send(28'h0000004, 1, 20'd2, 1'b0);
        drain();
        chk("err_count_after_rst", err_count, 0);
        rnd_mode = 1;
        for (int i = 0; i < 2002; i++) begin
            v = i == 0 ? 0 : i == 1 ? 832039 : int'($urandom_range(0, 832039));
            send(enc(v), 1, 20'(v), 1'b0);
        end
        drain();
        rnd_mode = 0;
        chk("err_count_random", err_count, 0);
        send(28'h0000002, 1, 20'd1, 1'b1);
        send(28'h0000003, 1, 20'd2, 1'b1);
        drain();
        chk("err_count_pre_clr", err_count, 2);
        rdy_hold = 0;
        send(28'h0000002, 1, 20'd1, 1'b1);
        wait_valid();
        clr_err = 1;
        rdy_hold = 1;
        @(posedge clock);
        #1;
        clr_err = 0;
        chk("clr_with_inc", err_count, 1);
        chk("clr_q_empty", q.size(), 0);
        clr_err = 1;
        @(posedge clock);
        #1;
        clr_err = 0;
        chk("clr_only", err_count, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
